spi_top: RTL and testbench



---
 rtl/spi_top.sv | 264 ++++++++++++++++++++++++++
 tb/tb_spi_top.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_top.sv
// rtl/spi_top.sv - SPI mode-0 loopback: selectable internal master driving an internal slave.

module spi_master_fsm #(
    parameter logic [7:0] TX_DATA     = 8'hA5,
    parameter int         HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_en,
    output logic sclk,
    output logic mosi,
    output logic cs_n,
    output logic rise
);
    localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, END} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sreg_q, sreg_d;
    logic            sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        case (state_q)
            IDLE: if (tx_en) begin
                state_d = SETUP;
                cs_n_d  = 1'b0;
                mosi_d  = TX_DATA[7];
                sreg_d  = TX_DATA;
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
            end
            SETUP: if (div_q == DIV_LAST) begin
                div_d   = '0;
                sclk_d  = 1'b1;
                state_d = SHIFT;
            end else begin
                div_d = div_q + 1'b1;
            end
            SHIFT: if (div_q == DIV_LAST) begin
                div_d  = '0;
                sclk_d = 1'b0;
                if (bit_q == 3'd7) begin
                    cs_n_d  = 1'b1;
                    state_d = END;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    mosi_d  = sreg_q[6];
                    sreg_d  = {sreg_q[6:0], 1'b0};
                    state_d = SETUP;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign rise = (state_q == SETUP) && (div_q == DIV_LAST);
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
endmodule

module spi_master_cnt #(
    parameter logic [7:0] TX_DATA     = 8'hA5,
    parameter int         HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_en,
    output logic sclk,
    output logic mosi,
    output logic cs_n,
    output logic rise
);
    localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

    logic [DW-1:0] div_q, div_d;
    logic [3:0]    phase_q, phase_d;
    logic [7:0]    sreg_q, sreg_d;
    logic          sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, end_q, end_d;

    // phase[0] is the SCLK level, phase[3:1] the bit index; end_q is the one-cycle gap
    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        sreg_d  = sreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        end_d   = 1'b0;
        if (cs_n_q) begin
            if (!end_q && tx_en) begin
                cs_n_d  = 1'b0;
                mosi_d  = TX_DATA[7];
                sreg_d  = TX_DATA;
                div_d   = '0;
                phase_d = '0;
                sclk_d  = 1'b0;
            end
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            phase_d = phase_q + 1'b1;
            if (!phase_q[0]) begin
                sclk_d = 1'b1;
            end else begin
                sclk_d = 1'b0;
                if (phase_q == 4'd15) begin
                    cs_n_d = 1'b1;
                    end_d  = 1'b1;
                end else begin
                    mosi_d = sreg_q[6];
                    sreg_d = {sreg_q[6:0], 1'b0};
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            phase_q <= '0;
            sreg_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            end_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            sreg_q  <= sreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            end_q   <= end_d;
        end
    end

    assign rise = !cs_n_q && (div_q == DIV_LAST) && !phase_q[0];
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
endmodule

module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       rise,
    input  logic       mosi,
    input  logic       cs_n,
    output logic [7:0] received_data,
    output logic       done
);
    logic [7:0] sreg_q, sreg_d, data_q, data_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_q, last_d, done_q, done_d;

    // rise is the strobe for the edge SCLK goes high; MOSI is stable there
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        last_d = 1'b0;
        done_d = 1'b0;
        if (cs_n) begin
            cnt_d = '0;
        end else if (rise) begin
            sreg_d = {sreg_q[6:0], mosi};
            cnt_d  = cnt_q + 1'b1;
            last_d = (cnt_q == 3'd7);
        end
        if (last_q) begin
            data_d = sreg_q;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            last_q <= last_d;
            done_q <= done_d;
        end
    end

    assign received_data = data_q;
    assign done          = done_q;
endmodule

module spi_top #(
    parameter int         MASTER      = 1,
    parameter logic [7:0] TX_DATA     = 8'hA5,
    parameter int         HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    output logic [7:0] received_data,
    output logic       done
);
    logic sclk, mosi, cs_n, rise;

    generate
        if (MASTER == 1) begin : g_fsm
            spi_master_fsm #(.TX_DATA(TX_DATA), .HALF_PERIOD(HALF_PERIOD)) u_master (
                .clk(clk), .rst(rst), .tx_en(tx_en),
                .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rise(rise)
            );
        end else begin : g_cnt
            spi_master_cnt #(.TX_DATA(TX_DATA), .HALF_PERIOD(HALF_PERIOD)) u_master (
                .clk(clk), .rst(rst), .tx_en(tx_en),
                .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rise(rise)
            );
        end
    endgenerate

    spi_slave u_slave (
        .clk(clk), .rst(rst), .rise(rise), .mosi(mosi), .cs_n(cs_n),
        .received_data(received_data), .done(done)
    );
endmodule

// File: tb/tb_spi_top.sv
// tb/tb_spi_top.sv - scoreboard bench for spi_top across both masters and a parameter sweep.

module tb_spi_top;
    localparam int N = 9;

    function automatic int cfg_m(input int i);
        return (i % 2 == 0 && i != 8) ? 1 : 0;
    endfunction

    function automatic logic [7:0] cfg_tx(input int i);
        case (i)
            0, 1:    return 8'hA5;
            2, 3:    return 8'h00;
            4, 5:    return 8'hFF;
            default: return 8'h3C;
        endcase
    endfunction

    function automatic int cfg_h(input int i);
        case (i)
            0, 1:       return 2;
            2, 3, 6, 8: return 1;
            default:    return 3;
        endcase
    endfunction

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] rd_w [N];
    logic       done_w [N];
    logic       sclk_w [N];
    logic       mosi_w [N];
    logic       cs_n_w [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        logic [7:0] rd;
        logic       dn;
        spi_top #(.MASTER(cfg_m(g)), .TX_DATA(cfg_tx(g)), .HALF_PERIOD(cfg_h(g))) dut (
            .clk(clk), .rst(rst), .tx_en(tx_en), .received_data(rd), .done(dn)
        );
        assign rd_w[g]   = rd;
        assign done_w[g] = dn;
        assign sclk_w[g] = dut.sclk;
        assign mosi_w[g] = dut.mosi;
        assign cs_n_w[g] = dut.cs_n;
    end

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    exp_t       exp_q [N][$];
    bit         inframe [N];
    int         e0 [N];
    logic [7:0] rd_m [N];
    logic       sclk_prev [N];
    int         bitk [N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // reference model of frame starts, advanced on every rising edge
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            int h;
            h = cfg_h(i);
            if (rst) begin
                inframe[i] = 1'b0;
                exp_q[i].delete();
                rd_m[i] = 8'h00;
            end else begin
                if (inframe[i] && cyc == e0[i] + 15*h + 1)
                    rd_m[i] = cfg_tx(i);
                if ((!inframe[i] || cyc >= e0[i] + 16*h + 2) && tx_en) begin
                    exp_t e;
                    inframe[i] = 1'b1;
                    e0[i] = cyc;
                    e.cyc = cyc + 15*h + 1;
                    e.data = cfg_tx(i);
                    exp_q[i].push_back(e);
                end else if (inframe[i] && cyc >= e0[i] + 16*h + 2) begin
                    inframe[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int         h, t;
            logic       cs_exp, sclk_exp;
            logic [7:0] txv;
            h = cfg_h(i);
            txv = cfg_tx(i);
            t = cyc - e0[i];
            cs_exp = 1'b1;
            sclk_exp = 1'b0;
            if (inframe[i] && t < 16*h) begin
                cs_exp = 1'b0;
                sclk_exp = ((t / h) % 2) == 1;
            end
            check($sformatf("cs_n[%0d]", i), 32'(cs_n_w[i]), 32'(cs_exp));
            check($sformatf("sclk[%0d]", i), 32'(sclk_w[i]), 32'(sclk_exp));
            check($sformatf("rdata[%0d]", i), 32'(rd_w[i]), 32'(rd_m[i]));

            if (cs_n_w[i] === 1'b1) bitk[i] = 0;
            if (sclk_w[i] === 1'b1 && sclk_prev[i] === 1'b0 && bitk[i] < 8) begin
                check($sformatf("mosi[%0d].bit%0d", i, bitk[i]), 32'(mosi_w[i]), 32'(txv[7-bitk[i]]));
                bitk[i]++;
            end
            sclk_prev[i] = sclk_w[i];

            if (done_w[i] !== 1'b0) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("done_unexpected[%0d]", i), 32'(done_w[i]), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    check($sformatf("done_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
                    check($sformatf("done_data[%0d]", i), 32'(rd_w[i]), 32'(e.data));
                end
            end else if (exp_q[i].size() != 0 && exp_q[i][0].cyc <= cyc) begin
                exp_t e;
                e = exp_q[i].pop_front();
                check($sformatf("done_missing[%0d]", i), 32'(done_w[i]), 32'd1);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            inframe[i] = 1'b0;
            e0[i] = 0;
            rd_m[i] = 8'h00;
            sclk_prev[i] = 1'b0;
            bitk[i] = 0;
        end
        rst = 1'b1;
        tx_en = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        repeat (2) @(negedge clk);
        tx_en = 1'b1;
        repeat (6) @(negedge clk);
        tx_en = 1'b0;
        repeat (80) @(negedge clk);

        tx_en = 1'b1;
        repeat (150) @(negedge clk);
        tx_en = 1'b0;
        repeat (80) @(negedge clk);

        tx_en = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tx_en = 1'b0;
        repeat (80) @(negedge clk);

        for (int i = 0; i < N; i++)
            check($sformatf("pending_done[%0d]", i), 32'(exp_q[i].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
